crypto_uart_rx: RTL and testbench

Serial-side decrypt front end for the 8-bit cryptosystem. Receives ciphertext bytes on a UART line (8N1, LSB first) and decrypts each byte with the 8-bit key. Presents plaintext on a registered valid/ready output for downstream logic such as a LED driver, a display, or the loop-back transmitter. It is the receive/decrypt end of the link whose transmit end encrypts bytes with the same key.

---
 rtl/crypto_pkg.sv | 11 +
 rtl/uart_bit_timer.sv | 22 ++
 rtl/crypto_uart_rx.sv | 75 +++++++
 tb/tb_crypto_uart_rx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/crypto_pkg.sv
// crypto_pkg: shared cipher functions, byte width and receiver state encoding
package crypto_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
  function automatic logic [BYTE_W-1:0] enc_byte(input logic [BYTE_W-1:0] k, input logic [BYTE_W-1:0] p);
    return p ^ k;
  endfunction
  function automatic logic [BYTE_W-1:0] dec_byte(input logic [BYTE_W-1:0] k, input logic [BYTE_W-1:0] c);
    return c ^ k;
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: reloadable bit-period counter, ticks after a half or full period then every full period
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic half,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] FULL = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2 - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= half ? HALF : FULL;
    else if (en) cnt <= (cnt == '0) ? FULL : cnt - 1'b1;
  end
  assign tick = en & ~load & (cnt == '0);
endmodule

// File: rtl/crypto_uart_rx.sv
// crypto_uart_rx: 8N1 UART receiver that decrypts each byte and presents it on a valid/ready register
module crypto_uart_rx
  import crypto_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 9600
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic [BYTE_W-1:0] key,
  output logic [BYTE_W-1:0] plain_data,
  output logic              plain_valid,
  input  logic              plain_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  rx_state_t state;
  logic rx_m, rx_s, tick, load;
  logic [BYTE_W-1:0] key_q, shift;
  logic [2:0] bit_idx;
  assign busy = state != IDLE;
  assign load = (state == IDLE) & ~rx_s;
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .half (1'b1),
    .en   (busy & (state != BREAK)),
    .tick (tick)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      {rx_s, rx_m} <= 2'b11;
      key_q       <= '0;
      shift       <= '0;
      bit_idx     <= '0;
      plain_data  <= '0;
      plain_valid <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      {rx_s, rx_m} <= {rx_m, rx};
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
      if (plain_valid && plain_ready) plain_valid <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state   <= START;
          key_q   <= key;
          bit_idx <= '0;
        end
        START: if (tick) state <= rx_s ? IDLE : DATA;
        DATA: if (tick) begin
          shift[bit_idx] <= rx_s;
          bit_idx        <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) state <= STOP;
        end
        STOP: if (tick) begin
          state <= rx_s ? IDLE : BREAK;
          if (!rx_s) frame_err <= 1'b1;
          else if (!plain_valid || plain_ready) begin
            plain_data  <= dec_byte(key_q, shift);
            plain_valid <= 1'b1;
          end else overrun <= 1'b1;
        end
        BREAK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crypto_uart_rx.sv
// tb_crypto_uart_rx: randomized and directed frames checked by a scoreboard against an XOR reference model
module tb_crypto_uart_rx;
  localparam int CPB = 16;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, plain_ready = 1'b1;
  logic [7:0] key = 8'h00;
  logic [7:0] plain_data;
  logic plain_valid, busy, frame_err, overrun;
  logic [7:0] exp_q[$];
  int checks = 0, errors = 0;
  int n_ferr = 0, n_ovr = 0, n_vcyc = 0;

  always #5 clk = ~clk;

  crypto_uart_rx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .key(key),
    .plain_data(plain_data), .plain_valid(plain_valid), .plain_ready(plain_ready),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // scoreboard monitor: every accepted byte must match the oldest expected byte
  always @(negedge clk) if (rst_n) begin
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (plain_valid) n_vcyc++;
    if (plain_valid && plain_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %02h expected none", plain_data);
      end else check("plain_data", int'(plain_data), int'(exp_q.pop_front()));
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic clear_counts();
    n_ferr = 0;
    n_ovr = 0;
    n_vcyc = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b;
    logic [7:0] d, k;
    logic [9:0] bits;
    repeat (3) @(negedge clk);
    check("reset_valid", int'(plain_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_data", int'(plain_data), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // single frame, latency and one-cycle valid
    clear_counts();
    key = 8'h5A;
    exp_q.push_back(8'h3C ^ 8'h5A);
    n = 0;
    fork
      send_frame(8'h3C, 1'b1);
      begin
        while (!plain_valid && n < 400) begin
          @(posedge clk);
          #1;
          n++;
        end
      end
    join
    repeat (4) @(negedge clk);
    check("latency", n, 2 + 1 + CPB / 2 + 8 * CPB + CPB);
    check("valid_cycles", n_vcyc, 1);
    check("t1_frame_err", n_ferr, 0);
    check("t1_overrun", n_ovr, 0);

    // back-to-back with consumer stalled
    clear_counts();
    key = 8'h00;
    plain_ready = 1'b0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (4) @(negedge clk);
    check("held_valid", int'(plain_valid), 1);
    check("held_data", int'(plain_data), 'hA5);
    check("overrun_count", n_ovr, 1);
    plain_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("t2_drained", exp_q.size(), 0);
    check("t2_valid_cleared", int'(plain_valid), 0);

    // framing error and line break
    clear_counts();
    key = 8'h5A;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    exp_q.push_back(8'h00 ^ 8'h5A);
    send_frame(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    check("frame_err_count", n_ferr, 1);
    check("t3_overrun", n_ovr, 0);
    check("t3_drained", exp_q.size(), 0);

    // start-bit glitch
    clear_counts();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    b = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) b++;
    end
    check("glitch_busy_le10", int'(b <= 10), 1);
    check("glitch_busy_nonzero", int'(b > 0), 1);
    check("glitch_idle", int'(busy), 0);
    check("glitch_flags", n_ferr + n_ovr + n_vcyc, 0);

    // key change mid-frame
    key = 8'h5A;
    exp_q.push_back(8'h3C ^ 8'h5A);
    fork
      send_frame(8'h3C, 1'b1);
      begin
        repeat (CPB * 4) @(negedge clk);
        key = 8'hFF;
      end
    join
    exp_q.push_back(8'h3C ^ 8'hFF);
    send_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    check("t5_drained", exp_q.size(), 0);

    // reset mid-frame during bit 4
    clear_counts();
    key = 8'h5A;
    bits = {1'b1, 8'h3C, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx = bits[5];
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_outputs", int'({plain_data, plain_valid, busy, frame_err, overrun}), 0);
    repeat (5) @(negedge clk);
    check("rst_idle", int'(busy), 0);
    exp_q.push_back(8'h3C ^ 8'h5A);
    send_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    check("t6_flags", n_ferr + n_ovr, 0);
    check("t6_drained", exp_q.size(), 0);

    // random bytes and keys
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      k = 8'($urandom);
      key = k;
      exp_q.push_back(d ^ k);
      send_frame(d, 1'b1);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("final_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
